// File: rtl/l1_ptr_ctrl.sv
// Per-stream L1 read pointers, line occupancy, L2 line-release credits and end status; optional checks via L1_PTR_CTRL_CHK_EN.
// All outputs reflect accepted updates one cycle later; updates are always accepted outside reset (no backpressure).
module l1_ptr_ctrl #(
  parameter int nstrms      = 64,
  parameter int nports      = 8,
  parameter int cl_size     = 8,
  parameter int clofs_width = $clog2(cl_size),
  parameter int nlines      = 4,
  parameter int ptr_width   = clofs_width + $clog2(nlines)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [nports*nstrms-1:0]    i_req_v,
  output logic [nports*nstrms-1:0]    i_req_r,
  input  logic [nstrms-1:0]           i_fill_v,
  input  logic [nstrms-1:0]           i_rst_end,
  input  logic [nstrms-1:0]           i_clr,
  output logic [nstrms*ptr_width-1:0] o_ptrs,
  output logic [nstrms-1:0]           o_rel_v,
  output logic [nstrms-1:0]           o_single_v,
  output logic [nstrms-1:0]           o_l1_end,
  output logic                        o_err
);

  localparam int kw = $clog2(nports + 1);
  localparam int vw = $clog2(nlines + 1);

  typedef enum logic [1:0] {
    st_idle   = 2'd0,
    st_active = 2'd1,
    st_ended  = 2'd2
  } strm_state_t;

  logic [ptr_width-1:0] ptr_q  [nstrms];
  logic [ptr_width-1:0] ptr_d  [nstrms];
  logic [vw-1:0]        vcnt_q [nstrms];
  logic [vw-1:0]        vcnt_d [nstrms];
  strm_state_t          st_q   [nstrms];
  strm_state_t          st_d   [nstrms];
  logic [nstrms-1:0]    rel_q;
  logic [nstrms-1:0]    rel_d;
  logic [nports*nstrms-1:0] acc;
`ifdef L1_PTR_CTRL_CHK_EN
  logic                 err_q;
  logic                 err_hit;
`endif

  assign i_req_r = {(nports*nstrms){~reset}};
  assign acc     = i_req_v & i_req_r;

  always_comb begin
    logic [kw-1:0]          k;
    logic [clofs_width:0]   sum;
    logic                   live;
    logic                   fill;
    logic                   carry;
    logic                   bad;
    rel_d = '0;
`ifdef L1_PTR_CTRL_CHK_EN
    err_hit = 1'b0;
`endif
    for (int s = 0; s < nstrms; s++) begin
      ptr_d[s]  = ptr_q[s];
      vcnt_d[s] = vcnt_q[s];
      st_d[s]   = st_q[s];
      bad       = 1'b0;
      live      = (st_q[s] != st_ended);
      k         = '0;
      for (int p = 0; p < nports; p++)
        k = k + kw'(acc[p*nstrms+s]);
      // An ended stream ignores both reads and fills.
      if (!live) k = '0;
      fill  = i_fill_v[s] & live;
      sum   = {1'b0, ptr_q[s][clofs_width-1:0]} + (clofs_width+1)'(k);
      carry = sum[clofs_width];
      ptr_d[s]  = ptr_q[s] + ptr_width'(k);
      vcnt_d[s] = vcnt_q[s] + vw'(fill) - vw'(carry);
`ifdef L1_PTR_CTRL_CHK_EN
      if (fill && !carry && vcnt_q[s] == vw'(nlines)) begin
        vcnt_d[s] = vw'(nlines);
        bad       = 1'b1;
      end
      if (carry && !fill && vcnt_q[s] == '0) begin
        vcnt_d[s] = '0;
        bad       = 1'b1;
      end
`endif
      rel_d[s] = carry;
      case (st_q[s])
        st_idle: begin
          if (fill)              st_d[s] = st_active;
          else if (i_rst_end[s]) st_d[s] = st_ended;
        end
        st_active: begin
          if (vcnt_d[s] == '0) st_d[s] = i_rst_end[s] ? st_ended : st_idle;
        end
        default: st_d[s] = st_q[s];
      endcase
      if (i_clr[s]) begin
        ptr_d[s]  = '0;
        vcnt_d[s] = '0;
        st_d[s]   = st_idle;
        rel_d[s]  = 1'b0;
        bad       = 1'b0;
      end
`ifdef L1_PTR_CTRL_CHK_EN
      err_hit = err_hit | bad;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < nstrms; s++) begin
        ptr_q[s]  <= '0;
        vcnt_q[s] <= '0;
        st_q[s]   <= st_idle;
      end
      rel_q <= '0;
    end else begin
      for (int s = 0; s < nstrms; s++) begin
        ptr_q[s]  <= ptr_d[s];
        vcnt_q[s] <= vcnt_d[s];
        st_q[s]   <= st_d[s];
      end
      rel_q <= rel_d;
    end
  end

`ifdef L1_PTR_CTRL_CHK_EN
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_q | err_hit;
  end
  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  assign o_rel_v = rel_q;

  always_comb begin
    o_ptrs     = '0;
    o_single_v = '0;
    o_l1_end   = '0;
    for (int s = 0; s < nstrms; s++) begin
      o_ptrs[s*ptr_width +: ptr_width] = ptr_q[s];
      o_single_v[s] = (vcnt_q[s] == vw'(1)) && (st_q[s] == st_active);
      o_l1_end[s]   = (st_q[s] == st_ended);
    end
  end

endmodule

// File: tb/tb_l1_ptr_ctrl.sv
// Directed bench for l1_ptr_ctrl; expectations follow L1_PTR_CTRL_CHK_EN when defined.
module tb_l1_ptr_ctrl;
  localparam int NS = 64;
  localparam int NP = 8;
  localparam int PW = 5;
`ifdef L1_PTR_CTRL_CHK_EN
  localparam bit chk_en = 1'b1;
`else
  localparam bit chk_en = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NP*NS-1:0]  i_req_v;
  logic [NP*NS-1:0]  i_req_r;
  logic [NS-1:0]     i_fill_v;
  logic [NS-1:0]     i_rst_end;
  logic [NS-1:0]     i_clr;
  logic [NS*PW-1:0]  o_ptrs;
  logic [NS-1:0]     o_rel_v;
  logic [NS-1:0]     o_single_v;
  logic [NS-1:0]     o_l1_end;
  logic              o_err;

  int n_cmp = 0;
  int n_bad = 0;

  l1_ptr_ctrl dut (
    .clk(clk), .reset(reset), .i_req_v(i_req_v), .i_req_r(i_req_r),
    .i_fill_v(i_fill_v), .i_rst_end(i_rst_end), .i_clr(i_clr),
    .o_ptrs(o_ptrs), .o_rel_v(o_rel_v), .o_single_v(o_single_v),
    .o_l1_end(o_l1_end), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] ptr_of(input int s);
    return o_ptrs[s*PW +: PW];
  endfunction

  // Ports 0..n-1 request stream s for the next edge.
  task automatic set_req(input int s, input int n);
    i_req_v = '0;
    for (int p = 0; p < n; p++) i_req_v[p*NS+s] = 1'b1;
  endtask

  task automatic idle_inputs();
    i_req_v  = '0;
    i_fill_v = '0;
    i_clr    = '0;
  endtask

  task automatic test_reset();
    logic [NP*NS-1:0] ones;
    ones = '1;
    reset = 1'b1; idle_inputs(); i_rst_end = '0;
    step(); step();
    n_cmp++; if (o_ptrs !== '0) begin n_bad++; $display("FAIL reset_ptrs got %h want 0", o_ptrs); end
    n_cmp++; if (o_l1_end !== '0) begin n_bad++; $display("FAIL reset_end got %h want 0", o_l1_end); end
    n_cmp++; if (i_req_r !== '0) begin n_bad++; $display("FAIL reset_rdy got nonzero want 0"); end
    n_cmp++; if (o_rel_v !== '0 || o_err !== 1'b0) begin n_bad++; $display("FAIL reset_rel_err got %h/%b want 0/0", o_rel_v, o_err); end
    reset = 1'b0;
    step();
    n_cmp++; if (i_req_r !== ones) begin n_bad++; $display("FAIL rdy_after_reset got not all ones want all ones"); end
  endtask

  task automatic test_full_line();
    i_fill_v[3] = 1'b1; step(); step(); idle_inputs();
    n_cmp++; if (o_single_v[3] !== 1'b0) begin n_bad++; $display("FAIL s3_two_lines single got %b want 0", o_single_v[3]); end
    set_req(3, 8); step(); idle_inputs();
    n_cmp++; if (ptr_of(3) !== 5'd8) begin n_bad++; $display("FAIL s3_ptr got %0d want 8", ptr_of(3)); end
    n_cmp++; if (o_rel_v[3] !== 1'b1) begin n_bad++; $display("FAIL s3_rel got %b want 1", o_rel_v[3]); end
    n_cmp++; if (o_single_v[3] !== 1'b1) begin n_bad++; $display("FAIL s3_single got %b want 1", o_single_v[3]); end
    step();
    n_cmp++; if (o_rel_v !== '0) begin n_bad++; $display("FAIL s3_rel_once got %h want 0", o_rel_v); end
  endtask

  task automatic test_fill_and_carry();
    i_fill_v[5] = 1'b1; step(); idle_inputs();
    set_req(5, 6); step(); idle_inputs();
    n_cmp++; if (ptr_of(5) !== 5'd6 || o_rel_v[5] !== 1'b0) begin n_bad++; $display("FAIL s5_ptr6 got %0d/%b want 6/0", ptr_of(5), o_rel_v[5]); end
    set_req(5, 3); i_fill_v[5] = 1'b1; step(); idle_inputs();
    n_cmp++; if (ptr_of(5) !== 5'd9) begin n_bad++; $display("FAIL s5_ptr9 got %0d want 9", ptr_of(5)); end
    n_cmp++; if (o_rel_v[5] !== 1'b1) begin n_bad++; $display("FAIL s5_rel got %b want 1", o_rel_v[5]); end
    n_cmp++; if (o_single_v[5] !== 1'b1) begin n_bad++; $display("FAIL s5_vcnt_kept single got %b want 1", o_single_v[5]); end
  endtask

  task automatic test_wrap();
    i_fill_v[10] = 1'b1; step(); step(); step(); step(); idle_inputs();
    for (int i = 0; i < 3; i++) begin set_req(10, 8); step(); end
    set_req(10, 7); step(); idle_inputs();
    n_cmp++; if (ptr_of(10) !== 5'd31 || o_rel_v[10] !== 1'b0) begin n_bad++; $display("FAIL s10_ptr31 got %0d/%b want 31/0", ptr_of(10), o_rel_v[10]); end
    n_cmp++; if (o_single_v[10] !== 1'b1) begin n_bad++; $display("FAIL s10_single got %b want 1", o_single_v[10]); end
    set_req(10, 1); step(); idle_inputs();
    n_cmp++; if (ptr_of(10) !== 5'd0) begin n_bad++; $display("FAIL s10_wrap got %0d want 0", ptr_of(10)); end
    n_cmp++; if (o_rel_v[10] !== 1'b1 || o_single_v[10] !== 1'b0) begin n_bad++; $display("FAIL s10_rel got %b/%b want 1/0", o_rel_v[10], o_single_v[10]); end
  endtask

  task automatic test_end_and_clr();
    i_fill_v[7] = 1'b1; step(); idle_inputs();
    set_req(7, 7); step();
    set_req(7, 1); i_rst_end[7] = 1'b1; step(); idle_inputs();
    n_cmp++; if (o_l1_end[7] !== 1'b1 || ptr_of(7) !== 5'd8) begin n_bad++; $display("FAIL s7_ended got %b/%0d want 1/8", o_l1_end[7], ptr_of(7)); end
    n_cmp++; if (o_rel_v[7] !== 1'b1) begin n_bad++; $display("FAIL s7_rel got %b want 1", o_rel_v[7]); end
    set_req(7, 3); i_fill_v[7] = 1'b1; step(); idle_inputs();
    n_cmp++; if (ptr_of(7) !== 5'd8 || o_l1_end[7] !== 1'b1) begin n_bad++; $display("FAIL s7_ignore got %0d/%b want 8/1", ptr_of(7), o_l1_end[7]); end
    n_cmp++; if (o_rel_v[7] !== 1'b0 || o_single_v[7] !== 1'b0) begin n_bad++; $display("FAIL s7_ignore_rel got %b/%b want 0/0", o_rel_v[7], o_single_v[7]); end
    set_req(7, 2); i_clr[7] = 1'b1; i_rst_end[7] = 1'b0; step(); idle_inputs();
    n_cmp++; if (ptr_of(7) !== 5'd0 || o_l1_end[7] !== 1'b0) begin n_bad++; $display("FAIL s7_clr got %0d/%b want 0/0", ptr_of(7), o_l1_end[7]); end
    n_cmp++; if (ptr_of(3) !== 5'd8 || ptr_of(5) !== 5'd9) begin n_bad++; $display("FAIL clr_isolation got %0d/%0d want 8/9", ptr_of(3), ptr_of(5)); end
    i_rst_end[20] = 1'b1; step(); i_rst_end[20] = 1'b0;
    n_cmp++; if (o_l1_end[20] !== 1'b1) begin n_bad++; $display("FAIL s20_idle_end got %b want 1", o_l1_end[20]); end
  endtask

  task automatic test_chk();
    i_fill_v[30] = 1'b1; step(); step(); step(); step(); step(); idle_inputs();
    n_cmp++; if (o_err !== chk_en) begin n_bad++; $display("FAIL chk_overflow err got %b want %b", o_err, chk_en); end
    for (int i = 0; i < 3; i++) begin set_req(30, 8); step(); end
    idle_inputs(); step();
    n_cmp++; if (o_single_v[30] !== chk_en) begin n_bad++; $display("FAIL chk_vcnt single got %b want %b", o_single_v[30], chk_en); end
    n_cmp++; if (o_err !== chk_en) begin n_bad++; $display("FAIL chk_sticky err got %b want %b", o_err, chk_en); end
  endtask

  task automatic test_reset_mid();
    set_req(3, 8); step(); idle_inputs();
    n_cmp++; if (o_rel_v[3] !== 1'b1 || ptr_of(3) !== 5'd16) begin n_bad++; $display("FAIL mid_pre got %b/%0d want 1/16", o_rel_v[3], ptr_of(3)); end
    set_req(3, 8); reset = 1'b1; step(); idle_inputs();
    n_cmp++; if (o_rel_v !== '0 || o_ptrs !== '0) begin n_bad++; $display("FAIL mid_reset rel %h ptrs nonzero=%b want 0", o_rel_v, |o_ptrs); end
    n_cmp++; if (o_l1_end !== '0 || o_single_v !== '0 || o_err !== 1'b0) begin n_bad++; $display("FAIL mid_reset_state end %h single %h err %b want 0", o_l1_end, o_single_v, o_err); end
    reset = 1'b0; step();
  endtask

  initial begin
    reset = 1'b1;
    i_req_v = '0; i_fill_v = '0; i_rst_end = '0; i_clr = '0;
    test_reset();
    test_full_line();
    test_fill_and_carry();
    test_wrap();
    test_end_and_clr();
    test_chk();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
